// File: rtl/ftdi_rx_deframer.sv
// ftdi_rx_deframer
//
// Purpose:
//   Pulls host bytes out of the FTDI read queue, finds packet boundaries,
//   strips the framing and streams the payload to the laser TX path over a
//   ready/valid handshake. Each packet is checked for a non-zero length and
//   an XOR checksum, and a one-cycle done or error pulse reports the result.
//
//   Frame on the wire: SYNC_BYTE, LEN (1-255), LEN payload bytes, CSUM,
//   where CSUM is the XOR of the payload bytes only.
//
// Ports:
//   clock      in   system clock
//   reset      in   synchronous, active-high reset
//   rdq_empty  in   read queue empty
//   data_rd    in   read queue data, valid the cycle after rdreq
//   rdreq      out  read queue pop strobe
//   out_ready  in   downstream accepts out_data
//   out_data   out  payload byte
//   out_valid  out  out_data valid
//   out_sop    out  first payload byte of packet (qualified by out_valid)
//   out_eop    out  last payload byte of packet (qualified by out_valid)
//   pkt_done   out  1-cycle pulse: packet ended with a good checksum
//   pkt_err    out  1-cycle pulse: bad checksum, zero length or timeout
//   busy       out  high whenever the deframer is not hunting for sync

module ftdi_rx_deframer #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int unsigned TIMEOUT   = 5_000_000,
    parameter int unsigned TO_W      = 24
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rdq_empty,
    input  logic [7:0] data_rd,
    output logic       rdreq,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_sop,
    output logic       out_eop,
    output logic       pkt_done,
    output logic       pkt_err,
    output logic       busy
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_HUNT,
        S_LEN,
        S_PAYLOAD,
        S_CSUM
    } state_t;

    state_t          state_q,     state_d;
    logic            pend_q,      pend_d;
    logic [7:0]      count_q,     count_d;
    logic [7:0]      csum_q,      csum_d;
    logic            first_q,     first_d;
    logic [TO_W-1:0] to_cnt_q,    to_cnt_d;
    logic [7:0]      out_data_q,  out_data_d;
    logic            out_valid_q, out_valid_d;
    logic            out_sop_q,   out_sop_d;
    logic            out_eop_q,   out_eop_d;
    logic            done_q,      done_d;
    logic            err_q,       err_d;

    logic            fetch_phase;
    logic            rdreq_c;
    logic            waiting;

    // A byte may be fetched only when no read is in flight and no payload
    // byte is still sitting on the output. Reset also blocks the pop so a
    // byte is never lost from the queue while the block is being cleared.
    assign fetch_phase = !pend_q && !out_valid_q;
    assign rdreq_c     = fetch_phase && !rdq_empty && !reset;
    assign waiting     = fetch_phase && rdq_empty && (state_q != S_HUNT);

    // Next-state logic. A captured byte (pend_q) is dispatched on the
    // current state; an accepted output byte advances the payload count;
    // otherwise the idle counter runs while starved mid-packet.
    always_comb begin
        state_d     = state_q;
        pend_d      = rdreq_c;
        count_d     = count_q;
        csum_d      = csum_q;
        first_d     = first_q;
        to_cnt_d    = to_cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_sop_d   = out_sop_q;
        out_eop_d   = out_eop_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        if (pend_q) begin
            to_cnt_d = '0;
            unique case (state_q)
                S_HUNT: begin
                    if (data_rd == SYNC_BYTE) begin
                        state_d = S_LEN;
                    end
                end
                S_LEN: begin
                    if (data_rd == 8'h00) begin
                        err_d   = 1'b1;
                        state_d = S_HUNT;
                    end else begin
                        count_d = data_rd;
                        csum_d  = 8'h00;
                        first_d = 1'b1;
                        state_d = S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    csum_d      = csum_q ^ data_rd;
                    out_data_d  = data_rd;
                    out_valid_d = 1'b1;
                    out_sop_d   = first_q;
                    out_eop_d   = (count_q == 8'd1);
                end
                S_CSUM: begin
                    if (data_rd == csum_q) begin
                        done_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = S_HUNT;
                end
                default: state_d = S_HUNT;
            endcase
        end else if (out_valid_q) begin
            // Backpressure only holds the byte; the idle counter is frozen.
            if (out_ready) begin
                out_valid_d = 1'b0;
                out_sop_d   = 1'b0;
                out_eop_d   = 1'b0;
                first_d     = 1'b0;
                count_d     = count_q - 8'd1;
                if (count_q == 8'd1) begin
                    state_d = S_CSUM;
                end
            end
        end else if (waiting) begin
            // Bytes already streamed are not retracted on abort; the
            // missing out_eop plus pkt_err tells downstream to drop them.
            if (to_cnt_q == TO_LAST) begin
                err_d    = 1'b1;
                to_cnt_d = '0;
                state_d  = S_HUNT;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end

        if (state_q == S_HUNT) begin
            to_cnt_d = '0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_HUNT;
            pend_q      <= 1'b0;
            count_q     <= 8'h00;
            csum_q      <= 8'h00;
            first_q     <= 1'b0;
            to_cnt_q    <= '0;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            count_q     <= count_d;
            csum_q      <= csum_d;
            first_q     <= first_d;
            to_cnt_q    <= to_cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign rdreq     = rdreq_c;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_sop   = out_sop_q;
    assign out_eop   = out_eop_q;
    assign pkt_done  = done_q;
    assign pkt_err   = err_q;
    assign busy      = (state_q != S_HUNT);

endmodule

// File: tb/tb_ftdi_rx_deframer.sv
// tb_ftdi_rx_deframer
//
// Purpose:
//   Self-checking bench for ftdi_rx_deframer. A behavioural read queue feeds
//   frames in; expected payload beats and done/error pulses are queued when
//   a frame is pushed and compared as the DUT produces them.
//
// Ports: none (top-level bench).

module tb_ftdi_rx_deframer;

    localparam int unsigned TB_TIMEOUT = 100;

    logic       clock = 1'b0;
    logic       reset;
    logic       rdq_empty;
    logic [7:0] data_rd;
    logic       rdreq;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_sop;
    logic       out_eop;
    logic       pkt_done;
    logic       pkt_err;
    logic       busy;

    always #5 clock = ~clock;

    ftdi_rx_deframer #(
        .SYNC_BYTE (8'hA5),
        .TIMEOUT   (TB_TIMEOUT),
        .TO_W      (24)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .rdq_empty (rdq_empty),
        .data_rd   (data_rd),
        .rdreq     (rdreq),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .pkt_done  (pkt_done),
        .pkt_err   (pkt_err),
        .busy      (busy)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       sop;
        logic       eop;
    } beat_t;

    typedef struct {
        int              n;
        logic [0:7][7:0] frame;
        int              np;
        logic [0:3][7:0] pay;
        logic [0:3]      sop;
        logic [0:3]      eop;
        int              npulse;
        logic [0:1]      perr;
        bit              stall;
    } vec_t;

    logic [7:0] fifo [$];
    beat_t      exp_pay [$];
    logic       exp_pulse [$];

    int         checks = 0;
    int         errors = 0;
    int         rd_count = 0;
    logic       rd_sample = 1'b0;
    bit         stall_mode = 1'b0;
    int         stall_cnt = 0;
    logic       prev_stall = 1'b0;
    logic [10:0] prev_bus = '0;

    vec_t       vecs [5];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Read queue model: one-cycle read latency, data changes just after the edge.
    always @(posedge clock) begin
        #1;
        if (rd_sample && fifo.size() > 0) begin
            data_rd = fifo.pop_front();
        end
        rdq_empty = (fifo.size() == 0);
    end

    // Downstream model: always ready, or in stall mode hold each byte 50 cycles.
    always @(posedge clock) begin
        #1;
        if (!stall_mode) begin
            out_ready = 1'b1;
            stall_cnt = 0;
        end else if (out_ready) begin
            out_ready = 1'b0;
            stall_cnt = 0;
        end else if (out_valid) begin
            stall_cnt++;
            if (stall_cnt == 50) begin
                out_ready = 1'b1;
            end
        end
    end

    // Scoreboard and protocol monitor, sampled mid-cycle.
    always @(negedge clock) begin
        beat_t b;
        logic  e;
        rd_sample = rdreq;
        if (!reset) begin
            if (rdreq) rd_count++;
            if (rdreq && rdq_empty) check_output("rdreq_while_empty", 32'(rdreq), 32'd0);
            if (rdreq && out_valid) check_output("rdreq_while_output", 32'(rdreq), 32'd0);
            if (prev_stall) begin
                check_output("stall_hold", 32'({out_valid, out_data, out_sop, out_eop}), 32'(prev_bus));
            end
            if (out_valid && out_ready) begin
                if (exp_pay.size() == 0) begin
                    check_output("unexpected_beat", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    b = exp_pay.pop_front();
                    check_output("beat", 32'({out_data, out_sop, out_eop}), 32'({b.d, b.sop, b.eop}));
                end
            end
            if (pkt_done || pkt_err) begin
                check_output("pulse_both", 32'(pkt_done & pkt_err), 32'd0);
                check_output("pulse_with_valid", 32'(out_valid), 32'd0);
                if (exp_pulse.size() == 0) begin
                    check_output("unexpected_pulse", 32'({pkt_done, pkt_err}), 32'd0);
                end else begin
                    e = exp_pulse.pop_front();
                    check_output("pulse_kind", 32'({pkt_done, pkt_err}), e ? 32'd1 : 32'd2);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_bus   = {out_valid, out_data, out_sop, out_eop};
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic wait_idle(input string name, input int budget);
        bit ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clock);
            if (fifo.size() == 0 && exp_pay.size() == 0 && exp_pulse.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        check_output({name, "_complete"}, 32'(ok), 32'd1);
    endtask

    task automatic apply_stimulus(input vec_t v, input string name);
        beat_t b;
        stall_mode = v.stall;
        rd_count   = 0;
        for (int i = 0; i < v.np; i++) begin
            b.d   = v.pay[i];
            b.sop = v.sop[i];
            b.eop = v.eop[i];
            exp_pay.push_back(b);
        end
        for (int i = 0; i < v.npulse; i++) exp_pulse.push_back(v.perr[i]);
        for (int i = 0; i < v.n; i++) fifo.push_back(v.frame[i]);
        wait_idle(name, 3000);
        check_output({name, "_busy"}, 32'(busy), 32'd0);
        check_output({name, "_rdreq_count"}, 32'(rd_count), 32'(v.n));
        stall_mode = 1'b0;
    endtask

    initial begin
        beat_t b;
        int    idle;
        int    accepts;
        bit    started;
        bit    seen;

        reset     = 1'b1;
        rdq_empty = 1'b1;
        data_rd   = 8'h00;
        out_ready = 1'b1;

        vecs[0] = '{6, {8'hA5, 8'h03, 8'h11, 8'h22, 8'h44, 8'h77, 8'h00, 8'h00},
                    3, {8'h11, 8'h22, 8'h44, 8'h00}, 4'b1000, 4'b0010, 1, 2'b00, 1'b0};
        vecs[1] = '{6, {8'h00, 8'h3C, 8'hA5, 8'h01, 8'h5A, 8'h5B, 8'h00, 8'h00},
                    1, {8'h5A, 8'h00, 8'h00, 8'h00}, 4'b1000, 4'b1000, 1, 2'b10, 1'b0};
        vecs[2] = '{6, {8'hA5, 8'h00, 8'hA5, 8'h01, 8'hFF, 8'hFF, 8'h00, 8'h00},
                    1, {8'hFF, 8'h00, 8'h00, 8'h00}, 4'b1000, 4'b1000, 2, 2'b10, 1'b0};
        vecs[3] = '{5, {8'hA5, 8'h02, 8'h10, 8'h20, 8'h30, 8'h00, 8'h00, 8'h00},
                    2, {8'h10, 8'h20, 8'h00, 8'h00}, 4'b1000, 4'b0100, 1, 2'b00, 1'b1};
        vecs[4] = '{5, {8'hA5, 8'h02, 8'hA5, 8'h5A, 8'hFF, 8'h00, 8'h00, 8'h00},
                    2, {8'hA5, 8'h5A, 8'h00, 8'h00}, 4'b1000, 4'b0100, 1, 2'b00, 1'b0};

        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check_output("reset_state",
                     32'({out_valid, out_sop, out_eop, pkt_done, pkt_err, busy, rdreq, out_data}), 32'd0);

        for (int i = 0; i < 5; i++) begin
            apply_stimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Starved mid-packet: payload 01, 02 streams, then the queue stays empty.
        b = '{8'h01, 1'b1, 1'b0};
        exp_pay.push_back(b);
        b = '{8'h02, 1'b0, 1'b0};
        exp_pay.push_back(b);
        exp_pulse.push_back(1'b1);
        fifo.push_back(8'hA5);
        fifo.push_back(8'h04);
        fifo.push_back(8'h01);
        fifo.push_back(8'h02);
        idle    = 0;
        started = 1'b0;
        seen    = 1'b0;
        for (int n = 0; n < 500; n++) begin
            @(negedge clock);
            if (started && pkt_err) begin
                seen = 1'b1;
                check_output("timeout_hunt", 32'(busy), 32'd0);
                break;
            end
            if (started && !out_valid) idle++;
            if (out_valid && out_ready && out_data == 8'h02) started = 1'b1;
        end
        check_output("timeout_seen", 32'(seen), 32'd1);
        check_output("timeout_idle_cycles", 32'(idle), 32'(TB_TIMEOUT));
        apply_stimulus(vecs[0], "after_timeout");

        // Reset two bytes into a five-byte payload.
        for (int i = 1; i <= 5; i++) begin
            b = '{8'(i), (i == 1), (i == 5)};
            exp_pay.push_back(b);
        end
        exp_pulse.push_back(1'b0);
        fifo.push_back(8'hA5);
        fifo.push_back(8'h05);
        for (int i = 1; i <= 5; i++) fifo.push_back(8'(i));
        fifo.push_back(8'h01);
        accepts = 0;
        for (int n = 0; n < 500 && accepts < 2; n++) begin
            @(negedge clock);
            if (out_valid && out_ready) accepts++;
        end
        check_output("reset_mid_accepts", 32'(accepts), 32'd2);
        @(posedge clock);
        #1;
        reset = 1'b1;
        exp_pay.delete();
        exp_pulse.delete();
        fifo.delete();
        rdq_empty = 1'b1;
        @(negedge clock);
        check_output("reset_rdreq", 32'(rdreq), 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check_output("reset_mid_outputs",
                     32'({out_valid, out_sop, out_eop, pkt_done, pkt_err, busy, rdreq, out_data}), 32'd0);
        repeat (20) @(negedge clock);
        apply_stimulus(vecs[0], "after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
